// File: rtl/mp_grf_pkg.sv
// Shared CPU package: register-file widths and pending-write counter limits.
package mp_grf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 2;
  localparam int CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/grf_pend_cnt.sv
// Saturating pending-producer counter for one architectural register.
module grf_pend_cnt
  import mp_grf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_clr
);
  localparam logic signed [CNT_W+1:0] MAXV = (CNT_W+2)'(cnt_max(CNT_W));

  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [CNT_W+1:0] v);
    if (v < 0) return '0;
    if (v > MAXV) return MAXV[CNT_W-1:0];
    return v[CNT_W-1:0];
  endfunction

  logic signed [CNT_W+1:0] cur_s, inc_s, dec_s;

  assign cur_s = $signed({2'b00, cnt});
  assign inc_s = $signed({{(CNT_W+1){1'b0}}, inc});
  assign dec_s = $signed({{CNT_W{1'b0}}, dec});

  // Busy view excludes this cycle's issue so a retiring write clears it at once.
  assign cnt_clr = sat_cnt(cur_s - dec_s);

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= sat_cnt(cur_s + inc_s - dec_s);
  end
endmodule

// File: rtl/mp_grf.sv
// Multi-port general register file with write-through bypass and per-register producer scoreboard.
module mp_grf
  import mp_grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [1:0]            wr_en,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic [1:0]            wr_clr,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt [DEPTH];
  logic [CNT_W-1:0]  cnt_clr [DEPTH];

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic [1:0]        we_eff, clr_eff;
  logic              clr_hit_iss, iss_acc;

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];
  assign wd0 = wr_data[0 +: DATA_W];
  assign wd1 = wr_data[DATA_W +: DATA_W];

  assign we_eff[0]  = wr_en[0] && (wa0 != '0);
  assign we_eff[1]  = wr_en[1] && (wa1 != '0);
  assign clr_eff    = we_eff & wr_clr;

  assign clr_hit_iss = (clr_eff[0] && (wa0 == iss_addr)) || (clr_eff[1] && (wa1 == iss_addr));
  assign iss_ready   = !reset && ((iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) || clr_hit_iss);
  assign iss_acc     = iss_valid && iss_ready && (iss_addr != '0);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we_eff[0]) mem[wa0] <= wd0;
      if (we_eff[1]) mem[wa1] <= wd1;
    end
  end

  assign cnt[0]     = '0;
  assign cnt_clr[0] = '0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
    logic [1:0] dec;
    assign dec = {1'b0, clr_eff[0] && (wa0 == ADDR_W'(r))}
               + {1'b0, clr_eff[1] && (wa1 == ADDR_W'(r))};

    grf_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (iss_acc && (iss_addr == ADDR_W'(r))),
      .dec     (dec),
      .cnt     (cnt[r]),
      .cnt_clr (cnt_clr[r])
    );
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] =
        (ra == '0)                   ? '0  :
        (wr_en[1] && (wa1 == ra))    ? wd1 :
        (wr_en[0] && (wa0 == ra))    ? wd0 : mem[ra];
    assign rd_busy[k] = (cnt_clr[ra] != '0);
  end
endmodule

// File: tb/tb_mp_grf.sv
// Directed scoreboard bench for mp_grf: stimulus pushes expectations, a negedge monitor compares.
module tb_mp_grf;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;

  mp_grf dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d0, d1;
    logic [1:0]  busy;
    logic        rdy;
    logic [2:0]  care;   // bit0 data, bit1 busy, bit2 iss_ready
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  bit stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.care[0]) begin
        chk({e.name, " rd0"}, rd_data[31:0], e.d0);
        chk({e.name, " rd1"}, rd_data[63:32], e.d1);
      end
      if (e.care[1]) chk({e.name, " busy"}, {30'd0, rd_busy}, {30'd0, e.busy});
      if (e.care[2]) chk({e.name, " iss_ready"}, {31'd0, iss_ready}, {31'd0, e.rdy});
    end
  end

  task automatic idle();
    reset = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    wr_clr = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  // Wait for the next edge, then leave inputs idle ready for the caller to override.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic clr);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
    wr_clr[p] = clr;
  endtask

  task automatic iss(input logic v, input logic [4:0] a);
    iss_valid = v;
    iss_addr = a;
  endtask

  task automatic expect_(input string n, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] busy, input logic rdy, input logic [2:0] care);
    exp_t e;
    e.name = n; e.d0 = d0; e.d1 = d1; e.busy = busy; e.rdy = rdy; e.care = care;
    q.push_back(e);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    // reset cycle: ready must be low even for a free register
    cyc(); reset = 1'b1; iss(1'b1, 5'd3);
    expect_("reset_ready", 0, 0, 2'b00, 1'b0, 3'b101);

    cyc(); rd(5, 7); iss(1'b0, 5'd9);
    expect_("post_reset", 0, 0, 2'b00, 1'b1, 3'b111);

    // write-through on both read ports, then stored
    cyc(); wr(0, 5, 32'h1234, 1'b0); rd(5, 5);
    expect_("bypass_r5", 32'h1234, 32'h1234, 2'b00, 1'b0, 3'b011);
    cyc(); rd(5, 5);
    expect_("stored_r5", 32'h1234, 32'h1234, 2'b00, 1'b0, 3'b011);

    // dual write collision: port 1 wins
    cyc(); wr(0, 7, 32'hAAAA, 1'b0); wr(1, 7, 32'h5555, 1'b0); rd(7, 7);
    expect_("collide_byp", 32'h5555, 32'h5555, 2'b00, 1'b0, 3'b011);
    cyc(); rd(7, 5);
    expect_("collide_st", 32'h5555, 32'h1234, 2'b00, 1'b0, 3'b011);

    // fill r3's counter to max
    cyc(); iss(1'b1, 3); rd(3, 0);
    expect_("iss3_a", 0, 0, 2'b00, 1'b1, 3'b110);
    cyc(); iss(1'b1, 3); rd(3, 0);
    expect_("iss3_b", 0, 0, 2'b01, 1'b1, 3'b110);
    cyc(); iss(1'b1, 3); rd(3, 0);
    expect_("iss3_c", 0, 0, 2'b01, 1'b1, 3'b110);
    cyc(); iss(1'b0, 3); rd(3, 3);
    expect_("full3", 0, 0, 2'b11, 1'b0, 3'b110);
    // clear + issue at max: accepted, counter stays at 3
    cyc(); wr(0, 3, 32'h33, 1'b1); iss(1'b1, 3); rd(3, 0);
    expect_("clr_iss3", 32'h33, 0, 2'b01, 1'b1, 3'b111);
    cyc(); iss(1'b0, 3); rd(3, 0);
    expect_("still_full3", 32'h33, 0, 2'b01, 1'b0, 3'b111);
    // double retire drops 3 -> 1, then last retire drops busy in-cycle
    cyc(); wr(0, 3, 32'h31, 1'b1); wr(1, 3, 32'h32, 1'b1); rd(3, 3); iss(1'b0, 3);
    expect_("dbl_clr3", 32'h32, 32'h32, 2'b11, 1'b1, 3'b111);
    cyc(); wr(1, 3, 32'h30, 1'b1); rd(3, 0);
    expect_("last_clr3", 32'h30, 0, 2'b01 ^ 2'b01, 1'b0, 3'b011);
    cyc(); rd(3, 0); iss(1'b0, 3);
    expect_("idle3", 32'h30, 0, 2'b00, 1'b1, 3'b111);

    // register 0 ignores everything
    cyc(); wr(0, 0, 32'hFFFF, 1'b1); iss(1'b1, 0); rd(0, 0);
    expect_("r0_wr", 0, 0, 2'b00, 1'b1, 3'b111);
    cyc(); rd(0, 0); iss(1'b0, 0);
    expect_("r0_after", 0, 0, 2'b00, 1'b1, 3'b111);

    // retire at zero saturates; data still written
    cyc(); wr(0, 4, 32'h4444, 1'b1); rd(4, 5);
    expect_("clr0_r4", 32'h4444, 32'h1234, 2'b00, 1'b0, 3'b011);
    cyc(); rd(4, 3); iss(1'b0, 4);
    expect_("r4_after", 32'h4444, 32'h30, 2'b00, 1'b1, 3'b111);
    cyc(); iss(1'b1, 4); rd(4, 0);
    cyc(); rd(4, 0);
    expect_("r4_one", 32'h4444, 0, 2'b01, 1'b0, 3'b011);

    // wr_clr without wr_en has no effect
    cyc(); iss(1'b1, 6); rd(6, 0);
    cyc(); wr_clr = 2'b10; wr_addr = {5'd6, 5'd0}; rd(6, 0);
    expect_("clr_noen", 0, 0, 2'b01, 1'b0, 3'b010);
    cyc(); rd(6, 0);
    expect_("clr_noen2", 0, 0, 2'b01, 1'b0, 3'b010);

    // reset mid-flight on r9
    cyc(); iss(1'b1, 9);
    cyc(); iss(1'b1, 9);
    cyc(); reset = 1'b1; wr(1, 9, 32'h99, 1'b1); rd(9, 5); iss(1'b1, 9);
    expect_("rst_byp", 32'h99, 32'h1234, 2'b01, 1'b0, 3'b111);
    cyc(); rd(9, 5); iss(1'b0, 9);
    expect_("after_rst", 0, 0, 2'b00, 1'b1, 3'b111);
    cyc(); rd(6, 3); iss(1'b0, 3);
    expect_("after_rst2", 0, 0, 2'b00, 1'b1, 3'b111);

    cyc();
    stim_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required stimulus completion");
    $fatal(1, "timeout");
  end
endmodule
